// File: rtl/pipelined_adder_32_pkg.sv
// Shared ALU definitions for the pipelined 32-bit add/subtract unit.
// Contents: width constants, add/sub opcode encoding and the per-stage payload struct.
// Optional feature macro: ALU_CMP_FLAGS_EN adds the compare-flag fields to the payload.
package pipelined_adder_32_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SLICE_W = 8;
    // One pipeline stage per slice; DATA_W must be a whole number of slices.
    localparam int unsigned NUM_SLC = DATA_W / SLICE_W;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    // Everything a stage register holds: finished result slices, the carry into the
    // next slice, operand slices not yet consumed (B already inverted for subtract)
    // and the operand sign bits needed for overflow.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] res;
        logic              carry;
        logic [DATA_W-1:0] a_rem;
        logic [DATA_W-1:0] b_rem;
        logic              a_msb;
        logic              b_msb;
        logic              ovf;
`ifdef ALU_CMP_FLAGS_EN
        logic              sub;
        logic              nz;
        logic              lt;
`endif
    } stage_t;

endpackage

// File: rtl/pipelined_adder_32_if.sv
// Handshake bundle between operand issue (master) and the pipelined adder (slave).
// Issue side : in_valid/in_ready, data_operandA/B, ctrl_sub.
// Result side: out_valid/out_ready, data_result, c_out, overflow,
//              plus isNotEqual/isLessThan when ALU_CMP_FLAGS_EN is defined.
interface pipelined_adder_32_if;
    import pipelined_adder_32_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_operandA;
    logic [DATA_W-1:0] data_operandB;
    logic              ctrl_sub;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_result;
    logic              c_out;
    logic              overflow;
`ifdef ALU_CMP_FLAGS_EN
    logic              isNotEqual;
    logic              isLessThan;
`endif

    modport master (
        output in_valid, data_operandA, data_operandB, ctrl_sub, out_ready,
        input  in_ready, out_valid, data_result, c_out, overflow
`ifdef ALU_CMP_FLAGS_EN
        , input isNotEqual, isLessThan
`endif
    );

    modport slave (
        input  in_valid, data_operandA, data_operandB, ctrl_sub, out_ready,
        output in_ready, out_valid, data_result, c_out, overflow
`ifdef ALU_CMP_FLAGS_EN
        , output isNotEqual, isLessThan
`endif
    );

endinterface

// File: rtl/adder_slice_stage.sv
// One pipeline stage: SLICE_W-bit carry-lookahead add of slice IDX plus its payload register.
// Ports: clk, rst_n        - clock, async active-low reset
//        prev_i            - payload from the previous stage (or the issue bundle for IDX 0)
//        rdy_next_i        - downstream stage (or consumer) can accept
//        stage_o           - registered payload of this stage
//        rdy_c_o           - this stage can load this cycle (combinational)
// Optional feature macro: ALU_CMP_FLAGS_EN (partial nonzero and less-than tracking).
module adder_slice_stage
    import pipelined_adder_32_pkg::*;
#(
    parameter int unsigned IDX = 0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  stage_t prev_i,
    input  logic   rdy_next_i,
    output stage_t stage_o,
    output logic   rdy_c_o
);

    localparam int unsigned LO = IDX * SLICE_W;

    stage_t             stage_q;
    stage_t             stage_d;
    logic [SLICE_W-1:0] a_c;
    logic [SLICE_W-1:0] b_c;
    logic [SLICE_W-1:0] g_c;
    logic [SLICE_W-1:0] p_c;
    logic [SLICE_W-1:0] sum_c;
    logic [SLICE_W:0]   cy_c;
    logic               acc_c;
    logic               prod_c;

    assign a_c = prev_i.a_rem[LO +: SLICE_W];
    assign b_c = prev_i.b_rem[LO +: SLICE_W];
    assign g_c = a_c & b_c;
    assign p_c = a_c ^ b_c;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, all in sum-of-products form.
    always_comb begin
        cy_c    = '0;
        acc_c   = 1'b0;
        prod_c  = 1'b1;
        cy_c[0] = prev_i.carry;
        for (int i = 0; i < int'(SLICE_W); i++) begin
            acc_c  = 1'b0;
            prod_c = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc_c  = acc_c | (g_c[j] & prod_c);
                prod_c = prod_c & p_c[j];
            end
            cy_c[i+1] = acc_c | (prod_c & prev_i.carry);
        end
    end

    assign sum_c = p_c ^ cy_c[SLICE_W-1:0];

    // Next payload: drop in this slice's sum, retire its operand bits, refresh the flags.
    always_comb begin
        stage_d                       = prev_i;
        stage_d.res[LO +: SLICE_W]    = sum_c;
        stage_d.carry                 = cy_c[SLICE_W];
        stage_d.a_rem[LO +: SLICE_W]  = '0;
        stage_d.b_rem[LO +: SLICE_W]  = '0;
        stage_d.ovf = (prev_i.a_msb == prev_i.b_msb) &
                      (stage_d.res[DATA_W-1] != prev_i.a_msb);
`ifdef ALU_CMP_FLAGS_EN
        stage_d.nz  = prev_i.nz | (|sum_c);
        stage_d.lt  = prev_i.sub & (stage_d.res[DATA_W-1] ^ stage_d.ovf);
`endif
    end

    // An empty stage always loads; a full one only when its contents move on.
    assign rdy_c_o = !stage_q.valid | rdy_next_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (rdy_c_o) begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/pipelined_adder_32.sv
// 32-bit add/subtract unit: NUM_SLC carry-lookahead slices, one per pipeline stage,
// with registered inter-slice carries and valid/ready handshake on both sides.
// Ports: clock   - rising-edge clock
//        reset_n - asynchronous active-low reset
//        bus     - pipelined_adder_32_if.slave (operands in, result and flags out)
// Optional feature macro: ALU_CMP_FLAGS_EN adds isNotEqual/isLessThan outputs.
module pipelined_adder_32
    import pipelined_adder_32_pkg::*;
(
    input logic                 clock,
    input logic                 reset_n,
    pipelined_adder_32_if.slave bus
);

    // pipe[0] is the incoming bundle, pipe[k+1] is the register of stage k.
    stage_t [NUM_SLC:0] pipe;
    logic   [NUM_SLC:0] rdy_c;
    logic               unused_tail;

    // Issue bundle: subtract becomes A + ~B + 1, the +1 entering as slice 0 carry-in.
    always_comb begin
        pipe[0]       = '0;
        pipe[0].valid = bus.in_valid;
        pipe[0].carry = (bus.ctrl_sub == ALU_OP_SUB);
        pipe[0].a_rem = bus.data_operandA;
        pipe[0].b_rem = (bus.ctrl_sub == ALU_OP_SUB) ? ~bus.data_operandB : bus.data_operandB;
        pipe[0].a_msb = bus.data_operandA[DATA_W-1];
        pipe[0].b_msb = pipe[0].b_rem[DATA_W-1];
`ifdef ALU_CMP_FLAGS_EN
        pipe[0].sub   = (bus.ctrl_sub == ALU_OP_SUB);
`endif
    end

    assign rdy_c[NUM_SLC] = bus.out_ready;

    for (genvar k = 0; k < int'(NUM_SLC); k++) begin : g_stage
        adder_slice_stage #(
            .IDX (k)
        ) u_stage (
            .clk        (clock),
            .rst_n      (reset_n),
            .prev_i     (pipe[k]),
            .rdy_next_i (rdy_c[k+1]),
            .stage_o    (pipe[k+1]),
            .rdy_c_o    (rdy_c[k])
        );
    end

    assign bus.in_ready    = rdy_c[0];
    assign bus.out_valid   = pipe[NUM_SLC].valid;
    assign bus.data_result = pipe[NUM_SLC].res;
    assign bus.c_out       = pipe[NUM_SLC].carry;
    assign bus.overflow    = pipe[NUM_SLC].ovf;
`ifdef ALU_CMP_FLAGS_EN
    assign bus.isNotEqual  = pipe[NUM_SLC].nz;
    assign bus.isLessThan  = pipe[NUM_SLC].lt;
`endif

    // Fields fully consumed by the last stage.
    assign unused_tail = ^{pipe[NUM_SLC].a_rem, pipe[NUM_SLC].b_rem,
                           pipe[NUM_SLC].a_msb, pipe[NUM_SLC].b_msb
`ifdef ALU_CMP_FLAGS_EN
                           , pipe[NUM_SLC].sub
`endif
                          };

endmodule

// File: tb/tb_pipelined_adder_32.sv
// Self-checking bench for pipelined_adder_32: directed vector table, stall and reset
// sequences, and a randomized run against a plain-arithmetic reference model.
module tb_pipelined_adder_32;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        ne;
        logic        lt;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        ne;
        logic        lt;
    } exp_t;

    logic clock;
    logic reset_n;

    pipelined_adder_32_if bus_if ();

    pipelined_adder_32 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    exp_t        exp_q[$];
    logic        held_v   = 1'b0;
    logic [31:0] held_res = '0;
    vec_t        tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: exact signed/unsigned arithmetic, then reduce to 32 bits.
    function automatic exp_t ref_calc(input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      ex;
        logic [32:0] w;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            e.res  = a - b;
            e.cout = (a >= b);
            ex     = sa - sb;
        end else begin
            w      = 33'(a) + 33'(b);
            e.res  = w[31:0];
            e.cout = w[32];
            ex     = sa + sb;
        end
        e.ovf = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
        e.ne  = (e.res != 32'h0);
        e.lt  = sub && (sa < sb);
        return e;
    endfunction

    task automatic check_result(input string tag, input exp_t e);
        chk({tag, "_result"}, bus_if.data_result, e.res);
        chk({tag, "_c_out"}, 32'(bus_if.c_out), 32'(e.cout));
        chk({tag, "_overflow"}, 32'(bus_if.overflow), 32'(e.ovf));
`ifdef ALU_CMP_FLAGS_EN
        chk({tag, "_isNotEqual"}, 32'(bus_if.isNotEqual), 32'(e.ne));
        chk({tag, "_isLessThan"}, 32'(bus_if.isLessThan), 32'(e.lt));
`endif
    endtask

    // One clock cycle: drive at negedge, evaluate handshakes, score outputs in order.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic ordy, output logic acc);
        exp_t e;
        @(negedge clock);
        bus_if.in_valid      = v;
        bus_if.data_operandA = a;
        bus_if.data_operandB = b;
        bus_if.ctrl_sub      = s;
        bus_if.out_ready     = ordy;
        #1;
        if (held_v) begin
            chk("stall_valid_hold", 32'(bus_if.out_valid), 32'd1);
            chk("stall_result_hold", bus_if.data_result, held_res);
        end
        held_v   = bus_if.out_valid && !ordy;
        held_res = bus_if.data_result;
        acc      = v && bus_if.in_ready;
        if (bus_if.out_valid && ordy) begin
            chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_result("sb", e);
                n_out++;
            end
        end
        if (acc) exp_q.push_back(ref_calc(a, b, s));
    endtask

    // Single op into an empty pipe: check 4-edge latency and the table's expected fields.
    task automatic run_single(input vec_t v, input int idx);
        int   lat;
        exp_t e;
        @(negedge clock);
        bus_if.in_valid      = 1'b1;
        bus_if.data_operandA = v.a;
        bus_if.data_operandB = v.b;
        bus_if.ctrl_sub      = v.sub;
        bus_if.out_ready     = 1'b1;
        #1;
        chk($sformatf("vec%0d_in_ready", idx), 32'(bus_if.in_ready), 32'd1);
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        bus_if.in_valid = 1'b0;
        while (!bus_if.out_valid && lat < 12) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        chk($sformatf("vec%0d_latency", idx), 32'(lat), 32'd4);
        e.res  = v.res;
        e.cout = v.cout;
        e.ovf  = v.ovf;
        e.ne   = v.ne;
        e.lt   = v.lt;
        check_result($sformatf("vec%0d", idx), e);
        @(posedge clock);
        @(negedge clock);
        chk($sformatf("vec%0d_drained", idx), 32'(bus_if.out_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          idx;
        int          cyc;
        int          out_before;
        logic [31:0] ops_a[8];
        logic [31:0] ops_b[8];
        logic        ops_s[8];

        //          a             b             sub   result        cout  ovf   ne    lt
        tbl[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{32'h0000_0009, 32'h0000_0009, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b1, 1'b0};

        bus_if.in_valid      = 1'b0;
        bus_if.data_operandA = '0;
        bus_if.data_operandB = '0;
        bus_if.ctrl_sub      = 1'b0;
        bus_if.out_ready     = 1'b0;
        reset_n              = 1'b0;

        // Reset state
        #3;
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("rst_result", bus_if.data_result, 32'h0);
        chk("rst_c_out", 32'(bus_if.c_out), 32'd0);
        chk("rst_overflow", 32'(bus_if.overflow), 32'd0);
`ifdef ALU_CMP_FLAGS_EN
        chk("rst_isNotEqual", 32'(bus_if.isNotEqual), 32'd0);
        chk("rst_isLessThan", 32'(bus_if.isLessThan), 32'd0);
`endif
        #19;
        reset_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 8; i++) run_single(tbl[i], i);

        // Eight back-to-back ops into a stalled consumer, released after the pipe fills
        for (int i = 0; i < 8; i++) begin
            ops_a[i] = $urandom;
            ops_b[i] = $urandom;
            ops_s[i] = 1'($urandom_range(0, 1));
        end
        idx        = 0;
        out_before = n_out;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (idx < 8) step(1'b1, ops_a[idx], ops_b[idx], ops_s[idx], cyc >= 8, acc);
            else         step(1'b0, '0, '0, 1'b0, 1'b1, acc);
            if (cyc == 6) begin
                chk("full_accepted", 32'(idx), 32'd4);
                chk("full_in_ready", 32'(bus_if.in_ready), 32'd0);
            end
            if (acc) idx++;
        end
        chk("burst_accepted", 32'(idx), 32'd8);
        chk("burst_delivered", 32'(n_out - out_before), 32'd8);
        chk("burst_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) step(1'b1, 32'h1111_0000 * i, 32'h0000_2222, 1'b0, 1'b0, acc);
        step(1'b0, '0, '0, 1'b0, 1'b0, acc);
        @(negedge clock);
        #1;
        chk("pre_reset_out_valid", 32'(bus_if.out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_reset_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("mid_reset_in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("mid_reset_result", bus_if.data_result, 32'h0);
        exp_q.delete();
        held_v = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        run_single(tbl[3], 8);

        // Randomized traffic with gaps on both sides
        idx = 0;
        cyc = 0;
        while (idx < 10000 && cyc < 60000) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = a;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            step($urandom_range(0, 3) != 0, a, b, s, $urandom_range(0, 3) != 0, acc);
            if (acc) idx++;
            cyc++;
        end
        chk("rand_accepted", 32'(idx), 32'd10000);
        for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
